// File: rtl/qspi_mem_ctrl_if.sv
// Core-side request/response bus of the quad-SPI memory controller.
// The core is the master; the controller is the slave.
interface qspi_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI sequencer: one 32-bit read/write per request as command, address, dummy and data nibbles.
// Define QSPI_QUAD_CMD_EN to send the command byte in quad mode; otherwise it goes out serially on io[0].
module qspi_mem_ctrl #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 6
) (
  input  logic           clock,
  input  logic           reset,
  qspi_mem_ctrl_if.slave mem,
  output logic           spi_cs_n,
  output logic           spi_sck,
  output logic [3:0]     io_out,
  output logic [3:0]     io_dir,
  input  logic [3:0]     io_in
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP} state_t;

`ifdef QSPI_QUAD_CMD_EN
  localparam int unsigned CMD_PERIODS = 2;
`else
  localparam int unsigned CMD_PERIODS = 8;
`endif
  localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] CMD_LAST   = 4'(CMD_PERIODS - 1);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h38;

  state_t      state, state_nx;
  logic [8:0]  div_cnt;
  logic        sck_hi;
  logic [3:0]  per_cnt;
  logic        wr;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] rsp_rdata;

  logic       in_spi;
  logic       half_end;
  logic       period_end;
  logic [7:0] cmd_byte;
  logic [2:0] addr_nib;

  assign in_spi     = state inside {CMD, ADDR, DUMMY, DATA};
  assign half_end   = (div_cnt == HALF_LAST);
  assign period_end = sck_hi && half_end;
  assign cmd_byte   = wr ? CMD_WRITE : CMD_READ;
  assign addr_nib   = 3'd5 - per_cnt[2:0];

  // State register plus the SCK divider and period counters that pace it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      sck_hi    <= 1'b0;
      per_cnt   <= '0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      rsp_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state <= state_nx;
      if (state_nx != state) begin
        div_cnt <= '0;
        sck_hi  <= 1'b0;
        per_cnt <= '0;
      end else if (in_spi) begin
        if (half_end) begin
          div_cnt <= '0;
          sck_hi  <= ~sck_hi;
          if (sck_hi) per_cnt <= per_cnt + 4'd1;
        end else begin
          div_cnt <= div_cnt + 9'd1;
        end
      end else if (state == GAP) begin
        div_cnt <= div_cnt + 9'd1;
      end

      if (state == IDLE && mem.req_valid) begin
        wr    <= mem.req_write;
        addr  <= mem.req_addr;
        wdata <= mem.req_wdata;
      end

      // Sample on the edge that raises SCK: last cycle of the low half.
      if (state == DATA && !wr && !sck_hi && half_end)
        rdata <= {rdata[27:0], io_in};

      if (state == DATA && state_nx == DONE && !wr)
        rsp_rdata <= rdata;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nx = state;
    case (state)
      IDLE:    if (mem.req_valid) state_nx = CMD;
      CMD:     if (period_end && per_cnt == CMD_LAST) state_nx = ADDR;
      ADDR:    if (period_end && per_cnt == 4'd5)
                 state_nx = (wr || DUMMY_CYCLES == 0) ? DATA : DUMMY;
      DUMMY:   if (period_end && per_cnt == DUMMY_LAST) state_nx = DATA;
      DATA:    if (period_end && per_cnt == 4'd7) state_nx = DONE;
      DONE:    state_nx = GAP;
      GAP:     if (div_cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Drive/direction only change with state or per_cnt, i.e. at the start of a low half.
  always_comb begin
    mem.req_ready = (state == IDLE);
    mem.rsp_valid = (state == DONE);
    spi_cs_n      = !in_spi;
    spi_sck       = sck_hi;
    io_out        = '0;
    io_dir        = '0;
    case (state)
      CMD: begin
`ifdef QSPI_QUAD_CMD_EN
        io_out = per_cnt[0] ? cmd_byte[3:0] : cmd_byte[7:4];
        io_dir = 4'hF;
`else
        io_out = {3'b000, cmd_byte[~per_cnt[2:0]]};
        io_dir = 4'b0001;
`endif
      end
      ADDR: begin
        io_out = addr[{addr_nib, 2'b00} +: 4];
        io_dir = 4'hF;
      end
      DATA: begin
        if (wr) begin
          io_out = wdata[{~per_cnt[2:0], 2'b00} +: 4];
          io_dir = 4'hF;
        end
      end
      default: ;
    endcase
  end

  assign mem.rsp_rdata = rsp_rdata;
endmodule
